pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter and next-PC unit: fetch-side successor to the single-cycle next-PC datapath.
//  Issues fetch addresses to instruction memory over a valid/ready handshake.
//  Resolves branch, jump and jump-register redirects one stage later (EX), flushes the wrong-path fetch,
//  and holds redirects that arrive while a fetch is still outstanding. Width and reset vector are parametrised.
// PARAMETERS
//  ADDR_W    32  PC / address width; must be > JADDR_W+2
//  IMM_W     16  branch immediate width (sign-extended, then shifted left 2)
//  JADDR_W   26  jump target field width
//  RESET_PC  0   PC value loaded on reset
//  COUNT_W   16  width of the saturating taken-redirect counter
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        asynchronous, active-high
//  stall         in   1        hazard hold; freezes sequential advance
//  imem_ready    in   1        imem accepts the current request
//  ex_valid      in   1        EX-stage instruction is real (not a bubble)
//  ex_pc         in   ADDR_W   PC of the EX-stage instruction
//  ex_pc_next    in   2        00 seq, 01 jump, 10 jump-reg, 11 treated as seq
//  ex_beq        in   1        branch if equal
//  ex_bne        in   1        branch if not equal
//  ex_zero       in   1        ALU zero flag for the EX instruction
//  ex_imm        in   IMM_W    branch offset, in words
//  ex_jaddr      in   JADDR_W  jump target field
//  ex_rs         in   ADDR_W   register data for jump-reg
//  imem_addr     out  ADDR_W   fetch address (= PC register)
//  imem_valid    out  1        fetch request valid
//  flush         out  1        kill the instruction currently in IF/ID (1-cycle pulse)
//  redirect      out  1        a redirect was taken this cycle (pulse)
//  misalign_err  out  1        sticky: jump-reg target had [1:0] != 0
//  taken_count   out  COUNT_W  saturating count of taken redirects
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imem_valid=0, flush=0, redirect=0, misalign_err=0, taken_count=0.
//  States:
//   IDLE  - one cycle after reset release, imem_valid=0 -> FETCH.
//   FETCH - imem_valid=1.
//   PEND  - imem_valid=1, redirect target held in pend_tgt.
//  take = ex_valid & ((ex_beq&ex_zero) | (ex_bne&~ex_zero) | ex_pc_next==01 | ex_pc_next==10).
//  Target, mod 2^ADDR_W:
//   branch   = ex_pc + 4 + (sext(ex_imm) << 2)
//   jump     = {ex_pc[ADDR_W-1:JADDR_W+2], ex_jaddr, 2'b00}
//   jump-reg = {ex_rs[ADDR_W-1:2], 2'b00}
//  Target priority: jump-reg > jump > branch.
//  Sequential advance: pc <= pc+4 when state FETCH & imem_valid & imem_ready & ~stall & ~take;
//   wraps silently at 2^ADDR_W.
//  Handshake: while imem_valid & ~imem_ready, imem_addr holds stable (no change mid-request).
//  On take:
//   - redirect=1 and flush=1 in the same cycle; taken_count increments, saturating at all-ones.
//   - If no request is outstanding (imem_ready=1 or state IDLE): pc <= target next edge, state FETCH.
//   - Else: pend_tgt <= target, state -> PEND; pc keeps the outstanding address.
//  PEND: on imem_ready, pc <= pend_tgt, state -> FETCH; the data returned for that beat is
//   wrong-path, so flush pulses again that cycle.
//  A new take while in PEND overwrites pend_tgt (youngest wins, since EX is in order).
//  Redirect beats stall: a take is never dropped because of stall; stall only blocks pc+4.
//  misalign_err sets on a taken jump-reg with ex_rs[1:0] != 0; cleared only by reset.
//  Latency: target appears on imem_addr one cycle after take (when not pending).
//  Asynchronous reset mid-PEND discards pend_tgt; first fetch after reset is at RESET_PC.
// TESTING
//  1. Reset, imem_ready=1, no takes: imem_addr = 0 (IDLE, valid=0), then 0, 4, 8, C on valid cycles.
//  2. EX beq, zero=1, ex_pc=0x20, imm=0xFFFE: redirect and flush pulse; next addr 0x1C; taken_count=1.
//  3. Jump with ex_pc=0xF0000010, jaddr=0x000100: next addr 0xF0000400.
//     Jump-reg with ex_rs=0x103: next addr 0x100, misalign_err=1.
//  4. imem_ready=0 at addr 0x40 when a jump to 0x200 resolves: addr stays 0x40.
//     Ready rises: second flush pulse, next addr 0x200.
//  5. stall=1 for 3 cycles at 0x80: addr holds 0x80. Branch taken during stall: next addr = target.
//  6. pc=0xFFFFFFFC, sequential: next addr 0x0. taken_count driven past 0xFFFF stays 0xFFFF.
//     Reset asserted mid-PEND: addr returns to RESET_PC asynchronously.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
//  imem_addr   fetch address driven by the sequencer
//  imem_valid  fetch request valid
//  imem_ready  imem accepts the current request
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic              imem_ready;

  modport master (output imem_addr, output imem_valid, input imem_ready);
  modport slave  (input imem_addr, input imem_valid, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter / next-PC unit on the fetch side.
// Issues fetch addresses over a valid/ready handshake. Branch, jump and
// jump-register redirects are resolved in EX, flush the wrong-path fetch,
// and are held in pend_tgt while a fetch request is still outstanding.
//  clk, reset     clock (rising edge), asynchronous active-high reset
//  stall          hazard hold, blocks sequential pc+4 only
//  imem           fetch handshake (master side)
//  ex_*           EX-stage control-flow information
//  flush          kill the instruction in IF/ID (combinational pulse)
//  redirect       a redirect is taken this cycle (combinational pulse)
//  misalign_err   sticky, taken jump-reg with nonzero target [1:0]
//  taken_count    saturating count of taken redirects
module pc_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       IMM_W    = 16,
  parameter int unsigned       JADDR_W  = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  pc_sequencer_if.master      imem,
  input  logic                ex_valid,
  input  logic [ADDR_W-1:0]   ex_pc,
  input  logic [1:0]          ex_pc_next,
  input  logic                ex_beq,
  input  logic                ex_bne,
  input  logic                ex_zero,
  input  logic [IMM_W-1:0]    ex_imm,
  input  logic [JADDR_W-1:0]  ex_jaddr,
  input  logic [ADDR_W-1:0]   ex_rs,
  output logic                flush,
  output logic                redirect,
  output logic                misalign_err,
  output logic [COUNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {IDLE, FETCH, PEND} state_t;

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   pc_q, pc_n;
  logic [ADDR_W-1:0]   pend_q, pend_n;
  logic [COUNT_W-1:0]  cnt_q, cnt_n;
  logic                mis_q, mis_n;
  logic                valid_q, valid_n;

  logic                is_j, is_jr, br_cond, take;
  logic [ADDR_W-1:0]   imm_sext, br_tgt, j_tgt, jr_tgt, target;

  // Redirect decode and target selection (jump-reg > jump > branch)
  assign is_j     = (ex_pc_next == 2'b01);
  assign is_jr    = (ex_pc_next == 2'b10);
  assign br_cond  = (ex_beq & ex_zero) | (ex_bne & ~ex_zero);
  assign take     = ex_valid & (br_cond | is_j | is_jr);

  assign imm_sext = {{(ADDR_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
  assign br_tgt   = ex_pc + ADDR_W'(4) + (imm_sext << 2);
  assign j_tgt    = {ex_pc[ADDR_W-1:JADDR_W+2], ex_jaddr, 2'b00};
  assign jr_tgt   = {ex_rs[ADDR_W-1:2], 2'b00};
  assign target   = is_jr ? jr_tgt : (is_j ? j_tgt : br_tgt);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      pend_q  <= pend_n;
      cnt_q   <= cnt_n;
      mis_q   <= mis_n;
      valid_q <= valid_n;
    end
  end

  // Next-state, next-PC and redirect pulses
  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    pend_n   = pend_q;
    cnt_n    = cnt_q;
    mis_n    = mis_q;
    flush    = 1'b0;
    redirect = 1'b0;

    if (take) begin
      // A take wins over stall and over an older pending target
      redirect = 1'b1;
      flush    = 1'b1;
      if (cnt_q != '1) cnt_n = cnt_q + COUNT_W'(1);
      if (is_jr && (ex_rs[1:0] != 2'b00)) mis_n = 1'b1;
      if ((state_q == IDLE) || imem.imem_ready) begin
        pc_n    = target;
        state_n = FETCH;
      end else begin
        pend_n  = target;
        state_n = PEND;
      end
    end else begin
      case (state_q)
        IDLE:  state_n = FETCH;
        FETCH: if (imem.imem_ready && !stall) pc_n = pc_q + ADDR_W'(4);
        PEND: begin
          // The beat returned now is wrong-path; kill it as we switch
          if (imem.imem_ready) begin
            pc_n    = pend_q;
            state_n = FETCH;
            flush   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    valid_n = (state_n != IDLE);
  end

  assign imem.imem_addr  = pc_q;
  assign imem.imem_valid = valid_q;
  assign misalign_err    = mis_q;
  assign taken_count     = cnt_q;

endmodule
